// File: rtl/pmp_check_stage.sv
// ============================================================================
// pmp_check_stage: registered request/response wrapper around the PMP/DMP unit
// Optional denied-access counter: define PMP_CHECK_FAULT_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pmp_check_stage #(
  parameter int unsigned PLEN  = 34,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DOM_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [PLEN-1:0]  req_addr_i,
  input  logic [2:0]       req_access_i,
  input  logic [1:0]       req_priv_i,
  input  logic [DOM_W-1:0] req_dom_i,
  output logic [PLEN-1:0]  pmp_addr_o,
  output logic [2:0]       pmp_access_o,
  output logic [1:0]       pmp_priv_o,
  output logic [DOM_W-1:0] pmp_dom_o,
  input  logic             pmp_allow_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [PLEN-1:0]  resp_addr_o,
  output logic             resp_fault_o,
  output logic [XLEN-1:0]  resp_cause_o,
  output logic [15:0]      fault_cnt_o,
  input  logic             cnt_clr_i
);

  localparam logic [2:0] CAUSE_INSTR_FAULT = 3'd1;
  localparam logic [2:0] CAUSE_LOAD_FAULT  = 3'd5;
  localparam logic [2:0] CAUSE_STORE_FAULT = 3'd7;

  logic             s1_valid_q, s1_valid_d;
  logic [PLEN-1:0]  s1_addr_q, s1_addr_d;
  logic [2:0]       s1_access_q, s1_access_d;
  logic [1:0]       s1_priv_q, s1_priv_d;
  logic [DOM_W-1:0] s1_dom_q, s1_dom_d;

  logic             s2_valid_q, s2_valid_d;
  logic [PLEN-1:0]  s2_addr_q, s2_addr_d;
  logic             s2_fault_q, s2_fault_d;
  logic [2:0]       s2_cause_q, s2_cause_d;

  logic s2_free;
  logic s1_adv;
  logic req_accept;
  logic resp_hs;
  logic [2:0] fault_cause;

  assign s2_free     = !s2_valid_q || resp_ready_i;
  assign s1_adv      = s1_valid_q && s2_free && !flush_i;
  assign req_ready_o = (!s1_valid_q || s2_free) && !flush_i;
  assign req_accept  = req_valid_i && req_ready_o;
  assign resp_hs     = s2_valid_q && resp_ready_i;

  // Store takes precedence over fetch; anything else reports as a load fault.
  always_comb begin
    fault_cause = CAUSE_LOAD_FAULT;
    if (s1_access_q[1])      fault_cause = CAUSE_STORE_FAULT;
    else if (s1_access_q[2]) fault_cause = CAUSE_INSTR_FAULT;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_addr_d   = s1_addr_q;
    s1_access_d = s1_access_q;
    s1_priv_d   = s1_priv_q;
    s1_dom_d    = s1_dom_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
    end else if (req_accept) begin
      s1_valid_d  = 1'b1;
      s1_addr_d   = req_addr_i;
      s1_access_d = req_access_i;
      s1_priv_d   = req_priv_i;
      s1_dom_d    = req_dom_i;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_addr_d  = s2_addr_q;
    s2_fault_d = s2_fault_q;
    s2_cause_d = s2_cause_q;
    if (flush_i) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_addr_d  = s1_addr_q;
      s2_fault_d = !pmp_allow_i;
      s2_cause_d = pmp_allow_i ? 3'd0 : fault_cause;
    end else if (resp_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_access_q <= '0;
      s1_priv_q   <= '0;
      s1_dom_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_fault_q  <= 1'b0;
      s2_cause_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_access_q <= s1_access_d;
      s1_priv_q   <= s1_priv_d;
      s1_dom_q    <= s1_dom_d;
      s2_valid_q  <= s2_valid_d;
      s2_addr_q   <= s2_addr_d;
      s2_fault_q  <= s2_fault_d;
      s2_cause_q  <= s2_cause_d;
    end
  end

  assign pmp_addr_o   = s1_addr_q;
  assign pmp_access_o = s1_access_q;
  assign pmp_priv_o   = s1_priv_q;
  assign pmp_dom_o    = s1_dom_q;

  assign resp_valid_o = s2_valid_q;
  assign resp_addr_o  = s2_addr_q;
  assign resp_fault_o = s2_fault_q;
  assign resp_cause_o = {{(XLEN-3){1'b0}}, s2_cause_q};

`ifdef PMP_CHECK_FAULT_CNT_EN
  logic [15:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (cnt_clr_i)
      fault_cnt_d = 16'h0000;
    else if (resp_hs && s2_fault_q && (fault_cnt_q != 16'hFFFF))
      fault_cnt_d = fault_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fault_cnt_q <= 16'h0000;
    else       fault_cnt_q <= fault_cnt_d;
  end

  assign fault_cnt_o = fault_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign fault_cnt_o    = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: doc/pmp_check_stage.md
Name: pmp_check_stage

Overview:
- Registered request/response pipeline wrapped around the combinational PMP/DMP permission unit.
- Captures an access request (address, access type, privilege, expected JIT domain) and drives it to the PMP unit from a register. Samples the unit's allow result and returns a response with an access-fault flag and a RISC-V exception cause.
- Sits between the MMU/LSU request path and the trap logic.

Parameters:
- PLEN, 34, physical address width (rv64: 56)
- XLEN, 64, width of the exception cause field

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: asynchronous, active-high
- flush_i  in  1  synchronous kill of all in-flight requests
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid and ready are both high
- req_addr_i  in  PLEN  physical address
- req_access_i  in  riscv::pmp_access_t  access type (R=3'b001, W=3'b010, X=3'b100)
- req_priv_i  in  riscv::priv_lvl_t  privilege level
- req_dom_i  in  riscv::dmp_domain_t  expected JIT domain
- pmp_addr_o  out  PLEN  to the PMP unit's addr_i
- pmp_access_o  out  riscv::pmp_access_t  to the PMP unit's access_type_i
- pmp_priv_o  out  riscv::priv_lvl_t  to the PMP unit's priv_lvl_i
- pmp_dom_o  out  riscv::dmp_domain_t  to the PMP unit's expdom_i
- pmp_allow_i  in  1  from the PMP unit's allow_o (combinational on pmp_*_o)
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  consumer ready
- resp_addr_o  out  PLEN  address of the checked request
- resp_fault_o  out  1  1 = access denied
- resp_cause_o  out  XLEN  exception cause; 0 when resp_fault_o=0
- fault_cnt_o  out  16  denied-access counter (see Optional Feature)
- cnt_clr_i  in  1  synchronous counter clear

Behaviour:
- Two stages:
  - S1 holds the accepted request. It drives pmp_*_o directly from flops.
  - S2 holds the response.
- Reset (async, rst_i=1):
  - s1_valid=0, s2_valid=0, so req_ready_o=1 and resp_valid_o=0.
  - All pmp_*_o, resp_addr_o, resp_fault_o, resp_cause_o and fault_cnt_o are 0.
  - Reset asserted mid-operation discards all in-flight requests. No response is produced for them.
- Advance rules:
  - s2_free = !s2_valid | resp_ready_i.
  - s1_adv = s1_valid & s2_free.
  - req_ready_o = !s1_valid | s2_free. This is combinational from state and resp_ready_i; there is no combinational path from req_valid_i.
- Latency: request accepted in cycle N gives resp_valid_o=1 in cycle N+2 when there is no back-pressure.
- Throughput: 1 request/cycle with resp_ready_i held high.
- S2 capture on s1_adv:
  - resp_addr_o = S1 address.
  - resp_fault_o = !pmp_allow_i.
  - Cause when faulting: W bit set gives 7 (store/AMO access fault); otherwise X bit set gives 1 (instruction access fault); otherwise 5 (load access fault).
  - Cause is zero-extended to XLEN and is 0 when not faulting.
- Response handshake:
  - S2 is held stable while resp_valid_o=1 and resp_ready_i=0.
  - S2 is released on handshake. If S1 advances in the same cycle, S2 reloads in that cycle with no bubble.
- S1 is held stable under back-pressure. pmp_*_o therefore stay constant, and allow is re-sampled only on the cycle S1 advances.
- Simultaneous accept and S1 advance: S1 reloads with the new request in the same cycle.
- flush_i=1:
  - Next cycle s1_valid=0 and s2_valid=0.
  - A request presented during flush is not accepted; req_ready_o=0 while flush_i=1.
  - A response handshake in the flush cycle still completes.
- Data flops do not require reset beyond the stated reset values. Valid flops must be reset.

Optional Feature:
- Macro: PMP_CHECK_FAULT_CNT_EN.
- Defined:
  - 16-bit counter increments once per response handshake with resp_fault_o=1.
  - Saturates at 16'hFFFF.
  - cnt_clr_i has priority over increment; counter reads 0 next cycle.
  - Reset value 0.
- Undefined:
  - No counter flops.
  - fault_cnt_o is tied to 0 and cnt_clr_i is ignored.

Test Plan:
- Reset, then req_valid_i=1, addr=34'h0_8000_1000, access=R, pmp_allow_i=1 -> resp_valid_o=1 at cycle +2, resp_fault_o=0, resp_cause_o=0, resp_addr_o=34'h0_8000_1000.
- Back-to-back W, X and R requests with pmp_allow_i=0 and resp_ready_i=1 -> three consecutive responses, causes 7, 1, 5, resp_fault_o=1 each; req_ready_o stays 1 throughout.
- Back-pressure: resp_ready_i=0 for 5 cycles while 3 requests are offered -> two accepted, then req_ready_o=0. resp_addr_o and pmp_addr_o are stable. Release -> responses in order with no loss or duplication.
- flush_i pulsed with both stages full -> resp_valid_o=0 next cycle and req_ready_o=1. No stale response appears afterwards.
- rst_i asserted asynchronously mid-cycle with S1/S2 valid -> resp_valid_o drops immediately, all outputs 0; after deassert, a fresh request completes normally in 2 cycles.
- With PMP_CHECK_FAULT_CNT_EN: 3 faulting and 2 allowed handshakes -> fault_cnt_o=3. cnt_clr_i plus a simultaneous fault -> 0. Preloaded at 16'hFFFF, then one fault -> stays 16'hFFFF. Without the macro -> fault_cnt_o=0 always.
